window3x3_gen: RTL and testbench
================================

Name: window3x3_gen

Overview:
- Consumer-side counterpart to the two-row line buffering used ahead of the convolution layers.
- Accepts a raster-order pixel stream, keeps two internal COLS-deep row shift registers, and assembles a 3x3 sliding window.
- Asserts win_valid only when the window lies fully inside the image, and reports the window position plus an end-of-frame pulse.
- Sits between the pixel source (input image or previous layer output) and the conv MAC array.

Parameters:
COLS, 28, image width in pixels (>= 3)
ROWS, 28, image height in pixels (>= 3)
BIT_WIDTH, 8, pixel width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
px_in  input  BIT_WIDTH  incoming pixel, raster order
px_valid  input  1  px_in accepted this cycle when high
flush  input  1  synchronous restart of frame position
win  output  9*BIT_WIDTH  window; win[BIT_WIDTH*(3*r+c) +: BIT_WIDTH] = pixel(out_row+r, out_col+c), r,c in 0..2
win_valid  output  1  win, out_row and out_col are valid this cycle
out_row  output  $clog2(ROWS)  top row index of the window
out_col  output  $clog2(COLS)  left column index of the window
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear to 0:
  - row and column shift registers, window registers, counters;
  - win, win_valid, out_row, out_col, frame_done.
- Internal counters col (0..COLS-1) and row (0..ROWS-1) give the position of the next accepted pixel.
- On an accepted pixel (px_valid=1, flush=0):
  - Row shift registers advance one position: RB0 takes px_in; RB1 takes the RB0 tail, which is the pixel from COLS samples earlier.
  - Each window row shifts left by one column:
    - new right column, row 2 = px_in;
    - new right column, row 1 = RB0 tail (previous row);
    - new right column, row 0 = RB1 tail (two rows back).
  - col increments. At COLS-1 it wraps to 0 and row increments.
  - At row ROWS-1 with col COLS-1, both counters wrap to 0.
- win_valid is registered and goes high the cycle after accepting a pixel with row>=2 and col>=2.
  - That cycle: out_row=row-2 and out_col=col-2, using the accepted pixel's indices.
  - Otherwise win_valid=0. The win, out_row and out_col values are don't-care but held.
- Latency: 1 cycle from the accepting edge to win_valid.
- Windows per frame: (ROWS-2)*(COLS-2). There are no windows across the row-wrap boundary (col 0 and col 1 of each row).
- px_valid=0 (stall): no register changes and win_valid=0 that cycle. Any gap length is allowed.
- frame_done is high the cycle after accepting pixel (ROWS-1, COLS-1).
  - It coincides with the final win_valid.
  - It is 0 in every other cycle.
- Back-to-back frames: the next frame starts at (0,0) immediately.
  - Stale row-register contents are not cleared. They are never exposed, because row<2 suppresses win_valid.
- flush=1: next cycle counters=0, win_valid=0, frame_done=0; window and row registers are left as is.
  - flush with px_valid=1 in the same cycle: flush wins and the pixel is discarded.
- Reset mid-frame: the next pixel after rst deasserts is treated as pixel (0,0).
- Widths: when ROWS or COLS is a power of 2, the counter width rule is max($clog2(N),1). Counter compares use the exact N-1 terminal value, never overflow.

Test Plan:
- Basic window, ROWS=COLS=5, px_in=row*5+col, px_valid held high:
  - first win_valid one cycle after pixel 12, out_row=0, out_col=0;
  - win elements r0c0..r2c2 = 0,1,2,5,6,7,10,11,12;
  - exactly 9 win_valid pulses per frame;
  - last window = 12,13,14,17,18,19,22,23,24 with frame_done=1 the same cycle.
- Random stalls: drive px_valid with a 50% random pattern, same 5x5 data -> identical sequence of 9 (out_row,out_col,win) tuples, and win_valid never high in a cycle following px_valid=0.
- Row wrap: during frame 1, check that no win_valid occurs after pixels at col 0 or col 1 -> out_col only takes the values 0,1,2.
- Back-to-back frames: stream two 5x5 frames, frame 2 data offset by 100 -> frame 2 first window = 100,101,102,105,106,107,110,111,112, and exactly one frame_done per frame.
- Flush and reset mid-frame:
  - flush after pixel 17 then a fresh frame -> windows match the basic scenario;
  - flush together with px_valid -> that pixel is dropped;
  - rst=0 pulse mid-frame -> all outputs 0 immediately (asynchronous), and the next frame is correct.
- Default config 28x28, pixels 0..783 (mod 256) -> 676 win_valid pulses and a single frame_done on the last one.

Source files
------------

// File: rtl/window3x3_gen.sv
// Slides a 3x3 window over a raster-order pixel stream using two COLS-deep row
// shift registers. Windows are only flagged valid when they lie fully inside the image.
module window3x3_gen #(
  parameter int COLS      = 28,
  parameter int ROWS      = 28,
  parameter int BIT_WIDTH = 8,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIT_WIDTH-1:0]   px_in,
  input  logic                   px_valid,
  input  logic                   flush,
  output logic [9*BIT_WIDTH-1:0] win,
  output logic                   win_valid,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   frame_done
);

  // Handshake: px_valid is a pure valid with no ready; the block accepts px_in on
  // every rising edge where px_valid=1 and flush=0, and never back-pressures.

  typedef logic [BIT_WIDTH-1:0] px_t;

  px_t           rb0_q [COLS];
  px_t           rb1_q [COLS];
  px_t           win_q [3][3];
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          accept;
  logic          col_last;
  logic          row_last;

  assign accept   = px_valid && !flush;
  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (flush) begin
      col_d = '0;
      row_d = '0;
    end else if (px_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Window position is the top-left corner, two behind the newest pixel.
      if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
        win_valid_d = 1'b1;
        out_row_d   = row_q - RW'(2);
        out_col_d   = col_q - CW'(2);
      end
      frame_done_d = row_last && col_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffers and window only move on accepted pixels; flush leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < COLS; i++) begin
        rb0_q[i] <= '0;
        rb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      rb0_q[0] <= px_in;
      rb1_q[0] <= rb0_q[COLS-1];
      for (int i = 1; i < COLS; i++) begin
        rb0_q[i] <= rb0_q[i-1];
        rb1_q[i] <= rb1_q[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= rb1_q[COLS-1];
      win_q[1][2] <= rb0_q[COLS-1];
      win_q[2][2] <= px_in;
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[BIT_WIDTH*(3*r+c) +: BIT_WIDTH] = win_q[r][c];
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: a 5x5 instance for scenario tables and corner
// sequences, plus a default 28x28 instance for a full-size frame.
module tb_window3x3_gen;

  typedef logic [77:0] tup_t;

  typedef struct {
    logic [7:0]  offset;
    bit          stall;
    logic [71:0] first_win;
    logic [71:0] last_win;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a_px;
  logic        a_valid, a_flush;
  logic [71:0] a_win;
  logic        a_wv, a_fd;
  logic [2:0]  a_orow, a_ocol;

  logic [7:0]  b_px;
  logic        b_valid, b_flush;
  logic [71:0] b_win;
  logic        b_wv, b_fd;
  logic [4:0]  b_orow, b_ocol;

  window3x3_gen #(.COLS(5), .ROWS(5), .BIT_WIDTH(8)) dut5 (
    .clk(clk), .rst(rst_n), .px_in(a_px), .px_valid(a_valid), .flush(a_flush),
    .win(a_win), .win_valid(a_wv), .out_row(a_orow), .out_col(a_ocol), .frame_done(a_fd)
  );

  window3x3_gen dut28 (
    .clk(clk), .rst(rst_n), .px_in(b_px), .px_valid(b_valid), .flush(b_flush),
    .win(b_win), .win_valid(b_wv), .out_row(b_orow), .out_col(b_ocol), .frame_done(b_fd)
  );

  // scoreboard state
  tup_t got_q[$];
  tup_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   fd_cnt = 0, fd_alone = 0, stall_viol = 0, col_viol = 0;
  tup_t fd_tup = '0;
  bit   acc_prev = 1'b0;
  int   b_wins = 0, b_fd_cnt = 0;
  bit   b_seen = 1'b0, b_fd_wv = 1'b0;
  logic [71:0] b_first = '0, b_fdwin = '0;
  logic [4:0]  b_fdrow = '0, b_fdcol = '0;
  vec_t vecs[4];

  // monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 1'b0;
    end else begin
      if (a_wv) begin
        got_q.push_back({a_orow, a_ocol, a_win});
        if (!acc_prev) stall_viol++;
        if (a_ocol > 3'd2) col_viol++;
      end
      if (a_fd) begin
        fd_cnt++;
        if (!a_wv) fd_alone++;
        fd_tup = {a_orow, a_ocol, a_win};
      end
      acc_prev = a_valid && !a_flush;
      if (b_wv) begin
        if (!b_seen) begin
          b_first = b_win;
          b_seen  = 1'b1;
        end
        b_wins++;
      end
      if (b_fd) begin
        b_fd_cnt++;
        b_fdwin = b_win;
        b_fdrow = b_orow;
        b_fdcol = b_ocol;
        b_fd_wv = b_wv;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic send_px(input logic [7:0] p, input bit v, input bit f);
    @(posedge clk);
    #1;
    a_px    = p;
    a_valid = v;
    a_flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) send_px(8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic frame5(input logic [7:0] offset, input bit stall);
    for (int i = 0; i < 25; i++) begin
      if (stall) begin
        int k = 0;
        while ($urandom_range(0, 1) == 1 && k < 6) begin
          send_px(8'($urandom_range(0, 255)), 1'b0, 1'b0);
          k++;
        end
      end
      send_px(8'(i) + offset, 1'b1, 1'b0);
    end
  endtask

  task automatic exp_frame5(input logic [7:0] offset);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [71:0] w;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            w[8*(3*i+j) +: 8] = 8'((r + i) * 5 + c + j) + offset;
        exp_q.push_back({3'(r), 3'(c), w});
      end
    end
  endtask

  task automatic clr();
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0; fd_alone = 0; stall_viol = 0; col_viol = 0;
    fd_tup = '0;
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_nwin"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        check($sformatf("%s_win%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    check({tag, "_stall_wv"}, 128'(stall_viol), 128'(0));
    check({tag, "_col_range"}, 128'(col_viol), 128'(0));
    check({tag, "_fd_alone"}, 128'(fd_alone), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tup_t g0;
    a_px = '0; a_valid = 1'b0; a_flush = 1'b0;
    b_px = '0; b_valid = 1'b0; b_flush = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_win", 128'(a_win), 128'(0));
    check("rst_wv", 128'(a_wv), 128'(0));
    check("rst_row_col", 128'({a_orow, a_ocol}), 128'(0));
    check("rst_fd", 128'(a_fd), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    vecs[0] = '{8'd0,   1'b0, {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0},
                              {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12}};
    vecs[1] = '{8'd0,   1'b1, {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0},
                              {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12}};
    vecs[2] = '{8'd100, 1'b0, {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100},
                              {8'd124, 8'd123, 8'd122, 8'd119, 8'd118, 8'd117, 8'd114, 8'd113, 8'd112}};
    vecs[3] = '{8'd100, 1'b1, {8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100},
                              {8'd124, 8'd123, 8'd122, 8'd119, 8'd118, 8'd117, 8'd114, 8'd113, 8'd112}};

    for (int v = 0; v < 4; v++) begin
      clr();
      frame5(vecs[v].offset, vecs[v].stall);
      idle(3);
      exp_frame5(vecs[v].offset);
      cmp_frames($sformatf("vec%0d", v));
      g0 = (got_q.size() > 0) ? got_q[0] : 'x;
      check($sformatf("vec%0d_first", v), 128'(g0), 128'({3'd0, 3'd0, vecs[v].first_win}));
      check($sformatf("vec%0d_fd_cnt", v), 128'(fd_cnt), 128'(1));
      check($sformatf("vec%0d_fd_last", v), 128'(fd_tup), 128'({3'd2, 3'd2, vecs[v].last_win}));
    end

    // back-to-back frames with no gap
    clr();
    frame5(8'd0, 1'b0);
    frame5(8'd100, 1'b0);
    idle(3);
    exp_frame5(8'd0);
    exp_frame5(8'd100);
    cmp_frames("b2b");
    check("b2b_fd_cnt", 128'(fd_cnt), 128'(2));
    g0 = (got_q.size() > 9) ? got_q[9] : 'x;
    check("b2b_f2_first", 128'(g0),
          128'({3'd0, 3'd0, 8'd112, 8'd111, 8'd110, 8'd107, 8'd106, 8'd105, 8'd102, 8'd101, 8'd100}));

    // flush after pixel 17, flush carries a pixel that must be dropped
    clr();
    for (int i = 0; i < 18; i++) send_px(8'(i), 1'b1, 1'b0);
    send_px(8'd99, 1'b1, 1'b1);
    send_px(8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_wv", 128'(a_wv), 128'(0));
    check("flush_fd", 128'(a_fd), 128'(0));
    idle(2);
    clr();
    frame5(8'd0, 1'b0);
    idle(3);
    exp_frame5(8'd0);
    cmp_frames("flush");
    check("flush_fd_cnt", 128'(fd_cnt), 128'(1));

    // asynchronous reset mid-frame while a window is being presented
    clr();
    for (int i = 0; i < 13; i++) send_px(8'(i), 1'b1, 1'b0);
    send_px(8'd0, 1'b0, 1'b0);
    check("prerst_wv", 128'(a_wv), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_win", 128'(a_win), 128'(0));
    check("midrst_wv", 128'(a_wv), 128'(0));
    check("midrst_row_col", 128'({a_orow, a_ocol}), 128'(0));
    check("midrst_fd", 128'(a_fd), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    clr();
    frame5(8'd0, 1'b0);
    idle(3);
    exp_frame5(8'd0);
    cmp_frames("rst");
    check("rst_fd_cnt", 128'(fd_cnt), 128'(1));

    // full 28x28 frame on the default instance
    b_wins = 0; b_fd_cnt = 0; b_seen = 1'b0;
    for (int i = 0; i < 784; i++) begin
      @(posedge clk);
      #1;
      b_px    = 8'(i % 256);
      b_valid = 1'b1;
    end
    @(posedge clk);
    #1 b_valid = 1'b0;
    idle(3);
    check("d28_nwin", 128'(b_wins), 128'(676));
    check("d28_fd_cnt", 128'(b_fd_cnt), 128'(1));
    check("d28_fd_wv", 128'(b_fd_wv), 128'(1));
    check("d28_fd_pos", 128'({b_fdrow, b_fdcol}), 128'({5'd25, 5'd25}));
    check("d28_first", 128'(b_first),
          128'({8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0}));
    check("d28_last", 128'(b_fdwin),
          128'({8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
